// File: rtl/r_cpu_seq_ctrl.sv
// r_cpu_seq_ctrl: four-phase IF/ID/EX/WB sequencer for the R-type datapath.
// Drives datapath load enables, ALU opcode, halt/overflow status and retire count.
module r_cpu_seq_ctrl #(
  parameter int CNT_W       = 16,
  parameter int OF_BLOCK_WB = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zf,
  input  logic             of,
  output logic             pc_we,
  output logic             ir_we,
  output logic             ab_we,
  output logic             f_we,
  output logic             write_reg,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             illegal,
  output logic             of_err,
  output logic             zf_q,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic             BLK_WB  = (OF_BLOCK_WB != 0);

  state_t           state_q, state_d;
  logic             single_q, single_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             illegal_q, illegal_d;
  logic             of_q, of_d;
  logic             of_err_q, of_err_d;
  logic             zf_q_q, zf_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_we_q, pc_we_d;
  logic             ir_we_q, ir_we_d;
  logic             ab_we_q, ab_we_d;
  logic             f_we_q, f_we_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;

  logic             dec_ok;
  logic [2:0]       dec_op;
  logic             of_ex;

  always_comb begin
    dec_ok = 1'b1;
    dec_op = 3'b000;
    unique case (func)
      6'b100100: dec_op = 3'b000;
      6'b100101: dec_op = 3'b001;
      6'b100110: dec_op = 3'b010;
      6'b100111: dec_op = 3'b011;
      6'b100000: dec_op = 3'b100;
      6'b100010: dec_op = 3'b101;
      6'b101011: dec_op = 3'b110;
      6'b000100: dec_op = 3'b111;
      default:   dec_ok = 1'b0;
    endcase
    if (op != 6'b000000) dec_ok = 1'b0;
  end

  // only add/sub can signal a meaningful overflow
  assign of_ex = of & ((alu_op_q == 3'b100) | (alu_op_q == 3'b101));

  always_comb begin
    state_d   = state_q;
    single_d  = single_q;
    alu_op_d  = alu_op_q;
    illegal_d = illegal_q;
    of_d      = of_q;
    of_err_d  = of_err_q;
    zf_q_d    = zf_q_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_IF;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = S_IF;
          single_d = 1'b1;
        end
      end
      S_IF: state_d = S_ID;
      S_ID: begin
        if (dec_ok) begin
          state_d  = S_EX;
          alu_op_d = dec_op;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EX: begin
        state_d  = S_WB;
        zf_q_d   = zf;
        of_d     = of_ex;
        of_err_d = of_err_q | of_ex;
      end
      S_WB: begin
        cnt_d = cnt_q + CNT_ONE;
        if (run && !single_q) begin
          state_d = S_IF;
        end else begin
          state_d  = S_IDLE;
          single_d = 1'b0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // enables are decoded from the next state so they line up with state_q
  always_comb begin
    pc_we_d = (state_d == S_IF);
    ir_we_d = (state_d == S_IF);
    ab_we_d = (state_d == S_ID);
    f_we_d  = (state_d == S_EX);
    wr_d    = (state_d == S_WB) & ~(BLK_WB & of_d);
    busy_d  = (state_d == S_IF) | (state_d == S_ID) |
              (state_d == S_EX) | (state_d == S_WB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      single_q  <= 1'b0;
      alu_op_q  <= 3'b000;
      illegal_q <= 1'b0;
      of_q      <= 1'b0;
      of_err_q  <= 1'b0;
      zf_q_q    <= 1'b0;
      cnt_q     <= '0;
      pc_we_q   <= 1'b0;
      ir_we_q   <= 1'b0;
      ab_we_q   <= 1'b0;
      f_we_q    <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      single_q  <= single_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
      of_q      <= of_d;
      of_err_q  <= of_err_d;
      zf_q_q    <= zf_q_d;
      cnt_q     <= cnt_d;
      pc_we_q   <= pc_we_d;
      ir_we_q   <= ir_we_d;
      ab_we_q   <= ab_we_d;
      f_we_q    <= f_we_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
    end
  end

  assign pc_we     = pc_we_q;
  assign ir_we     = ir_we_q;
  assign ab_we     = ab_we_q;
  assign f_we      = f_we_q;
  assign write_reg = wr_q;
  assign alu_op    = alu_op_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;
  assign of_err    = of_err_q;
  assign zf_q      = zf_q_q;
  assign inst_cnt  = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_r_cpu_seq_ctrl.sv
// tb_r_cpu_seq_ctrl: directed test of the R-type sequencer.
// A second instance with a 2-bit counter covers counter wrap.
module tb_r_cpu_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic       step;
  logic [5:0] op;
  logic [5:0] func;
  logic       zf;
  logic       of;

  logic        pc_we, ir_we, ab_we, f_we, write_reg, busy;
  logic        illegal, of_err, zf_q;
  logic [2:0]  alu_op, state;
  logic [15:0] inst_cnt;

  logic        pc_we2, ir_we2, ab_we2, f_we2, wr2, busy2;
  logic        ill2, of_err2, zf_q2;
  logic [2:0]  alu_op2, state2;
  logic [1:0]  cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  r_cpu_seq_ctrl #(.CNT_W(16), .OF_BLOCK_WB(1)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .op(op), .func(func), .zf(zf), .of(of),
    .pc_we(pc_we), .ir_we(ir_we), .ab_we(ab_we), .f_we(f_we),
    .write_reg(write_reg), .alu_op(alu_op), .busy(busy),
    .illegal(illegal), .of_err(of_err), .zf_q(zf_q),
    .inst_cnt(inst_cnt), .state(state)
  );

  r_cpu_seq_ctrl #(.CNT_W(2), .OF_BLOCK_WB(1)) dut2 (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .op(op), .func(func), .zf(zf), .of(of),
    .pc_we(pc_we2), .ir_we(ir_we2), .ab_we(ab_we2), .f_we(f_we2),
    .write_reg(wr2), .alu_op(alu_op2), .busy(busy2),
    .illegal(ill2), .of_err(of_err2), .zf_q(zf_q2),
    .inst_cnt(cnt2), .state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_step(input logic [5:0] f, input logic ofv,
                         input logic zfv, input logic [2:0] ea,
                         input logic ew, input logic extra);
    @(negedge clk);
    op = 6'b000000;
    func = f;
    of = ofv;
    zf = zfv;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("st_ir_we", 32'(ir_we), 1);
    chk("st_pc_we", 32'(pc_we), 1);
    @(negedge clk);
    chk("st_ab_we", 32'(ab_we), 1);
    @(negedge clk);
    chk("st_f_we", 32'(f_we), 1);
    chk("st_alu_op", 32'(alu_op), 32'(ea));
    if (extra) step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("st_wr", 32'(write_reg), 32'(ew));
    chk("st_zf_q", 32'(zf_q), 32'(zfv));
    @(negedge clk);
    chk("st_idle", 32'(state), 0);
    chk("st_busy", 32'(busy), 0);
  endtask

  logic [5:0] funcs [8];
  logic [1:0] wrap_exp [5];

  initial begin
    funcs = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
              6'b100000, 6'b100010, 6'b101011, 6'b000100};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1;
    run = 1'b0;
    step = 1'b0;
    op = 6'b000000;
    func = 6'b100000;
    zf = 1'b0;
    of = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_en", 32'({pc_we, ir_we, ab_we, f_we, write_reg, busy}), 0);
    chk("rst_flags", 32'({illegal, of_err, zf_q}), 0);
    chk("rst_cnt", 32'(inst_cnt), 0);

    // back-to-back add under run, run dropped during third instruction
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("run_if", 32'({ir_we, pc_we, ab_we}), 32'b110);
      chk("run_if_st", 32'(state), 1);
      chk("run_cnt", 32'(inst_cnt), i);
      if (i == 2) run = 1'b0;
      @(negedge clk);
      chk("run_id", 32'({ir_we, ab_we, f_we}), 32'b010);
      @(negedge clk);
      chk("run_ex", 32'({ab_we, f_we, write_reg}), 32'b010);
      chk("run_alu", 32'(alu_op), 4);
      @(negedge clk);
      chk("run_wb", 32'({f_we, write_reg}), 32'b01);
      chk("run_wb_st", 32'(state), 4);
    end
    @(negedge clk);
    chk("run_stop_st", 32'(state), 0);
    chk("run_stop_cnt", 32'(inst_cnt), 3);
    chk("run_stop_en", 32'({pc_we, ir_we, busy}), 0);

    // single-step sweep of every legal func
    do_reset();
    for (int i = 0; i < 8; i++)
      do_step(funcs[i], 1'b0, 1'(i), 3'(i), 1'b1, (i == 3));
    chk("sweep_cnt", 32'(inst_cnt), 8);
    @(negedge clk);
    chk("sweep_idle", 32'(state), 0);

    // overflow on sub blocks write-back; overflow on and is ignored
    do_step(6'b100010, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0);
    chk("of_err", 32'(of_err), 1);
    chk("of_cnt", 32'(inst_cnt), 9);
    do_step(6'b100100, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    chk("of_and_cnt", 32'(inst_cnt), 10);
    chk("of_err_sticky", 32'(of_err), 1);
    of = 1'b0;

    // illegal op halts after ID
    do_reset();
    @(negedge clk);
    op = 6'b000010;
    func = 6'b100000;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("ill_if", 32'(ir_we), 1);
    @(negedge clk);
    chk("ill_id_ab", 32'(ab_we), 1);
    @(negedge clk);
    chk("ill_halt", 32'(state), 5);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_en", 32'({f_we, write_reg, busy}), 0);
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step = 1'(i);
      @(negedge clk);
      chk("ill_stay", 32'(state), 5);
      chk("ill_no_wr", 32'({ir_we, f_we, write_reg}), 0);
    end
    chk("ill_cnt", 32'(inst_cnt), 0);
    rst = 1'b1;
    run = 1'b0;
    step = 1'b0;
    @(negedge clk);
    chk("ill_rst_st", 32'(state), 0);
    chk("ill_rst_flag", 32'(illegal), 0);

    // illegal func with op=0 under run
    rst = 1'b0;
    op = 6'b000000;
    func = 6'b000000;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("ill2_halt", 32'(state), 5);
    chk("ill2_flag", 32'(illegal), 1);
    chk("ill2_alu", 32'(alu_op), 0);

    // counter wrap on the 2-bit instance, then reset during EX
    do_reset();
    func = 6'b100000;
    run = 1'b1;
    @(negedge clk);
    chk("wrap_if", 32'(state2), 1);
    for (int k = 0; k < 5; k++) begin
      repeat (4) @(negedge clk);
      chk("wrap_cnt", 32'(cnt2), 32'(wrap_exp[k]));
    end
    repeat (2) @(negedge clk);
    chk("rex_ex", 32'(state), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rex_st", 32'(state), 0);
    chk("rex_en", 32'({pc_we, ir_we, ab_we, f_we, write_reg, busy}), 0);
    chk("rex_cnt", 32'(inst_cnt), 0);
    chk("rex_cnt2", 32'(cnt2), 0);
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    chk("rex_no_wr", 32'({write_reg, state}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
